rf_text_screen_arb: RTL and testbench

- Port-A controller for the 64-bit text screen RAM (AWID-bit word address, byte enables, read latency 2).
- Shares the port between the CPU bus slave and an internal block engine. The engine runs fill (clear screen or region) and overlap-safe copy (scroll) commands.
- Sits between the bus interface and the RAM port A pins. Port B (video fetch) is untouched.

---
 rtl/rf_text_screen_pkg.sv | 12 +
 rtl/rf_text_screen_eng.sv | 149 ++++++++++++++
 rtl/rf_text_screen_arb.sv | 126 ++++++++++++
 tb/tb_rf_text_screen_arb.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_text_screen_pkg.sv
// Shared types for the text-screen RAM port-A arbiter and its block engine.
package rf_text_screen_pkg;

    localparam logic OP_FILL = 1'b0;
    localparam logic OP_COPY = 1'b1;

    // Who owns the read data returning on the RAM port.
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_ENG} owner_t;

    typedef enum logic [2:0] {IDLE, FILL, CRD, CWAIT, CWR, DONE} eng_state_t;

endpackage

// File: rtl/rf_text_screen_eng.sv
// Block engine: fill and overlap-safe copy over the text RAM, one cell per granted slot.
module rf_text_screen_eng
    import rf_text_screen_pkg::*;
#(
    parameter int AWID = 14
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_op_i,
    input  logic [AWID-1:0] cmd_src_i,
    input  logic [AWID-1:0] cmd_dst_i,
    input  logic [AWID:0]   cmd_len_i,
    input  logic [63:0]     cmd_fill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            slot_req,
    output logic            slot_we,
    output logic [AWID-1:0] slot_adr,
    output logic [63:0]     slot_dat,
    input  logic            slot_gnt,
    input  logic            rd_vld,
    input  logic [63:0]     rd_dat
);

    localparam logic [AWID:0] ONE_LEN = (AWID+1)'(1);

    eng_state_t      state;
    logic [AWID-1:0] src, dst, step;
    logic [AWID:0]   rem;
    logic            desc;
    logic [63:0]     fill, hold;
    logic            ready_q, busy_q, done_q;

    // Descending copies step by -1, which is all-ones modulo 2^AWID.
    assign step = desc ? {AWID{1'b1}} : AWID'(1);

    assign cmd_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            src     <= '0;
            dst     <= '0;
            rem     <= '0;
            desc    <= 1'b0;
            fill    <= '0;
            hold    <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        fill    <= cmd_fill_i;
                        rem     <= cmd_len_i;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        // memmove rule: a destination above the source copies from the top down
                        if (cmd_op_i == OP_COPY && cmd_dst_i > cmd_src_i) begin
                            desc <= 1'b1;
                            src  <= cmd_src_i + AWID'(cmd_len_i - ONE_LEN);
                            dst  <= cmd_dst_i + AWID'(cmd_len_i - ONE_LEN);
                        end else begin
                            desc <= 1'b0;
                            src  <= cmd_src_i;
                            dst  <= cmd_dst_i;
                        end
                        if (cmd_len_i == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= (cmd_op_i == OP_COPY) ? CRD : FILL;
                        end
                    end
                end
                FILL: begin
                    if (slot_gnt) begin
                        dst <= dst + step;
                        rem <= rem - ONE_LEN;
                        if (rem == ONE_LEN) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                CRD: begin
                    if (slot_gnt) begin
                        src   <= src + step;
                        state <= CWAIT;
                    end
                end
                CWAIT: begin
                    if (rd_vld) begin
                        hold  <= rd_dat;
                        state <= CWR;
                    end
                end
                CWR: begin
                    if (slot_gnt) begin
                        dst <= dst + step;
                        rem <= rem - ONE_LEN;
                        if (rem == ONE_LEN) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= CRD;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        slot_req = 1'b0;
        slot_we  = 1'b0;
        slot_adr = dst;
        slot_dat = fill;
        case (state)
            FILL: begin
                slot_req = 1'b1;
                slot_we  = 1'b1;
            end
            CRD: begin
                slot_req = 1'b1;
                slot_adr = src;
            end
            CWR: begin
                slot_req = 1'b1;
                slot_we  = 1'b1;
                slot_dat = hold;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rf_text_screen_arb.sv
// Text-screen RAM port-A arbiter: round-robin between the CPU slave and the block engine.
module rf_text_screen_arb
    import rf_text_screen_pkg::*;
#(
    parameter  int TEXT_CELL_COUNT = 16384,
    parameter  int RD_LAT          = 2,
    localparam int AWID            = $clog2(TEXT_CELL_COUNT)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cpu_cs_i,
    input  logic            cpu_we_i,
    input  logic [7:0]      cpu_sel_i,
    input  logic [AWID-1:0] cpu_adr_i,
    input  logic [63:0]     cpu_dat_i,
    output logic [63:0]     cpu_dat_o,
    output logic            cpu_ack_o,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_op_i,
    input  logic [AWID-1:0] cmd_src_i,
    input  logic [AWID-1:0] cmd_dst_i,
    input  logic [AWID:0]   cmd_len_i,
    input  logic [63:0]     cmd_fill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            ram_cs_o,
    output logic            ram_we_o,
    output logic [7:0]      ram_sel_o,
    output logic [AWID-1:0] ram_adr_o,
    output logic [63:0]     ram_dat_o,
    input  logic [63:0]     ram_dat_i
);

    logic            slot_req, slot_we;
    logic [AWID-1:0] slot_adr;
    logic [63:0]     slot_dat;
    logic            cpu_req, cpu_gnt, eng_gnt;
    logic            cpu_pend, wr_ack_q, last_cpu;
    owner_t          own_pipe [RD_LAT];
    owner_t          own_nxt;
    owner_t          own_ret;

    rf_text_screen_eng #(.AWID(AWID)) u_eng (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op_i),
        .cmd_src_i   (cmd_src_i),
        .cmd_dst_i   (cmd_dst_i),
        .cmd_len_i   (cmd_len_i),
        .cmd_fill_i  (cmd_fill_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .slot_req    (slot_req),
        .slot_we     (slot_we),
        .slot_adr    (slot_adr),
        .slot_dat    (slot_dat),
        .slot_gnt    (eng_gnt),
        .rd_vld      (own_ret == OWN_ENG),
        .rd_dat      (ram_dat_i)
    );

    assign own_ret   = own_pipe[RD_LAT-1];
    assign cpu_ack_o = wr_ack_q | (own_ret == OWN_CPU);
    assign cpu_dat_o = (own_ret == OWN_CPU) ? ram_dat_i : '0;

    // Reset gates the CPU request so the RAM pins stay idle while held in reset.
    assign cpu_req = rst_ni & cpu_cs_i & ~cpu_pend & ~cpu_ack_o;
    assign cpu_gnt = cpu_req & (~slot_req | ~last_cpu);
    assign eng_gnt = slot_req & ~cpu_gnt;

    always_comb begin
        own_nxt = OWN_NONE;
        if (cpu_gnt && !cpu_we_i)
            own_nxt = OWN_CPU;
        else if (eng_gnt && !slot_we)
            own_nxt = OWN_ENG;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cpu_pend <= 1'b0;
            wr_ack_q <= 1'b0;
            last_cpu <= 1'b0;
            for (int i = 0; i < RD_LAT; i++)
                own_pipe[i] <= OWN_NONE;
        end else begin
            wr_ack_q <= cpu_gnt & cpu_we_i;
            if (cpu_gnt)
                cpu_pend <= 1'b1;
            else if (cpu_ack_o)
                cpu_pend <= 1'b0;
            if (cpu_gnt)
                last_cpu <= 1'b1;
            else if (eng_gnt)
                last_cpu <= 1'b0;
            own_pipe[0] <= own_nxt;
            for (int i = 1; i < RD_LAT; i++)
                own_pipe[i] <= own_pipe[i-1];
        end
    end

    always_comb begin
        ram_cs_o  = 1'b0;
        ram_we_o  = 1'b0;
        ram_sel_o = '0;
        ram_adr_o = '0;
        ram_dat_o = '0;
        if (cpu_gnt) begin
            ram_cs_o  = 1'b1;
            ram_we_o  = cpu_we_i;
            ram_sel_o = cpu_sel_i;
            ram_adr_o = cpu_adr_i;
            ram_dat_o = cpu_dat_i;
        end else if (eng_gnt) begin
            ram_cs_o  = 1'b1;
            ram_we_o  = slot_we;
            ram_sel_o = 8'hFF;
            ram_adr_o = slot_adr;
            ram_dat_o = slot_we ? slot_dat : '0;
        end
    end

endmodule

// File: tb/tb_rf_text_screen_arb.sv
// Bench for rf_text_screen_arb: behavioural 2-cycle RAM, array reference model, directed + random steps.
module tb_rf_text_screen_arb;

    localparam int N  = 16384;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_cs = 1'b0, cpu_we = 1'b0;
    logic [7:0]    cpu_sel = '0;
    logic [AW-1:0] cpu_adr = '0;
    logic [63:0]   cpu_wdat = '0;
    logic [63:0]   cpu_rdat;
    logic          cpu_ack;
    logic          cmd_valid = 1'b0, cmd_op = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_src = '0, cmd_dst = '0;
    logic [AW:0]   cmd_len = '0;
    logic [63:0]   cmd_fill = '0;
    logic          busy, done;
    logic          ram_cs, ram_we;
    logic [7:0]    ram_sel;
    logic [AW-1:0] ram_adr;
    logic [63:0]   ram_wdat;
    logic [63:0]   ram_rdat = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_text_screen_arb dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_cs_i(cpu_cs), .cpu_we_i(cpu_we), .cpu_sel_i(cpu_sel), .cpu_adr_i(cpu_adr),
        .cpu_dat_i(cpu_wdat), .cpu_dat_o(cpu_rdat), .cpu_ack_o(cpu_ack),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_src_i(cmd_src), .cmd_dst_i(cmd_dst), .cmd_len_i(cmd_len), .cmd_fill_i(cmd_fill),
        .busy_o(busy), .done_o(done),
        .ram_cs_o(ram_cs), .ram_we_o(ram_we), .ram_sel_o(ram_sel), .ram_adr_o(ram_adr),
        .ram_dat_o(ram_wdat), .ram_dat_i(ram_rdat)
    );

    // Port-A RAM: byte-enabled write, registered address + registered data (latency 2).
    logic [63:0]   mem [N] = '{default: '0};
    logic [AW-1:0] rd_adr_q = '0;
    logic          rd_en_q = 1'b0;
    always @(posedge clk) begin
        if (ram_cs && ram_we)
            for (int b = 0; b < 8; b++)
                if (ram_sel[b]) mem[ram_adr][8*b +: 8] <= ram_wdat[8*b +: 8];
        rd_adr_q <= ram_adr;
        rd_en_q  <= ram_cs & ~ram_we;
        if (rd_en_q) ram_rdat <= mem[rd_adr_q];
    end

    int unsigned wr_cnt = 0;
    int unsigned done_cnt = 0;
    always @(negedge clk) begin
        if (ram_cs && ram_we) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    logic [63:0] ref_mem [N] = '{default: '0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_fill(input int dst, input int len, input logic [63:0] val);
        for (int i = 0; i < len; i++) ref_mem[(dst + i) % N] = val;
    endtask

    task automatic ref_copy(input int src, input int dst, input int len);
        if (dst > src)
            for (int i = len - 1; i >= 0; i--) ref_mem[(dst + i) % N] = ref_mem[(src + i) % N];
        else
            for (int i = 0; i < len; i++) ref_mem[(dst + i) % N] = ref_mem[(src + i) % N];
    endtask

    task automatic cmp_mem(input string tag);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < N; i++)
            if (mem[i] !== ref_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        chk($sformatf("%s bad_cells(first=%0d)", tag, first), 64'(bad), 64'd0);
    endtask

    task automatic cpu_xfer(input logic we, input logic [AW-1:0] adr, input logic [7:0] sel,
                            input logic [63:0] wd, output logic [63:0] rd, output int lat);
        cpu_cs = 1'b1; cpu_we = we; cpu_adr = adr; cpu_sel = sel; cpu_wdat = wd;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!cpu_ack && lat < 20);
        rd = cpu_rdat;
        cpu_cs = 1'b0; cpu_we = 1'b0;
        tick();
    endtask

    task automatic cpu_wr(input string tag, input logic [AW-1:0] adr, input logic [63:0] d,
                          input logic [7:0] sel, input int max_lat);
        logic [63:0] rd;
        int lat;
        cpu_xfer(1'b1, adr, sel, d, rd, lat);
        for (int b = 0; b < 8; b++)
            if (sel[b]) ref_mem[adr][8*b +: 8] = d[8*b +: 8];
        if (max_lat == 1) chk({tag, " wr_lat"}, 64'(lat), 64'd1);
        else chk({tag, " wr_lat_ok"}, 64'(lat <= max_lat), 64'd1);
    endtask

    task automatic cpu_rd(input string tag, input logic [AW-1:0] adr, input int max_lat);
        logic [63:0] rd;
        int lat;
        cpu_xfer(1'b0, adr, 8'hFF, 64'd0, rd, lat);
        if (max_lat == 2) chk({tag, " rd_lat"}, 64'(lat), 64'd2);
        else chk({tag, " rd_lat_ok"}, 64'(lat <= max_lat), 64'd1);
        chk({tag, " rd_data"}, rd, ref_mem[adr]);
    endtask

    task automatic run_cmd(input string tag, input logic op, input int src, input int dst,
                           input int len, input logic [63:0] fill);
        int unsigned w0, d0;
        int n;
        logic seen;
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        w0 = wr_cnt; d0 = done_cnt;
        cmd_valid = 1'b1; cmd_op = op; cmd_src = AW'(src); cmd_dst = AW'(dst);
        cmd_len = (AW+1)'(len); cmd_fill = fill;
        tick();
        cmd_valid = 1'b0;
        chk({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        if (len == 0) chk({tag, " len0_done_next"}, 64'(done), 64'd1);
        n = 0;
        while (!done && n < 4 * len + 40) begin tick(); n++; end
        seen = done;
        chk({tag, " done_seen"}, 64'(seen), 64'd1);
        tick();
        chk({tag, " done_pulses"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, " ram_writes"}, 64'(wr_cnt - w0), 64'(len));
        chk({tag, " idle_ready_busy"}, 64'({cmd_ready, busy}), 64'b10);
        if (op) ref_copy(src, dst, len);
        else ref_fill(dst, len, fill);
        cmp_mem(tag);
    endtask

    initial begin
        int unsigned w0;
        int n;
        logic [63:0] fa;

        // reset state
        repeat (3) tick();
        chk("reset_ctrl", 64'({cmd_ready, busy, done, cpu_ack, ram_cs, ram_we, ram_sel}), 64'(14'b1_0000_0000_00000));
        chk("reset_cpu_dat", cpu_rdat, 64'd0);
        chk("reset_ram_adr_dat", ram_wdat | 64'(ram_adr), 64'd0);
        rst_n = 1'b1;
        tick();

        // CPU only: byte-masked write then read
        cpu_wr("cpu5", 14'd5, 64'h1122334455667788, 8'h0F, 1);
        cpu_rd("cpu5", 14'd5, 2);
        chk("cpu5_const", mem[5], 64'h0000000055667788);

        // fill 80 cells at 100
        run_cmd("fill80", 1'b0, 100, 100, 80, 64'h0720);
        chk("fill80_c100", mem[100], 64'h0720);
        chk("fill80_c179", mem[179], 64'h0720);
        chk("fill80_c99", mem[99], 64'h0);
        chk("fill80_c180", mem[180], 64'h0);

        // scroll: preload index, copy up then overlapping copy down
        for (int i = 0; i < 160; i++) cpu_wr("preload", AW'(i), 64'(i), 8'hFF, 1);
        run_cmd("copy_up", 1'b1, 80, 0, 80, 64'h0);
        chk("copy_up_c0", mem[0], 64'd80);
        chk("copy_up_c79", mem[79], 64'd159);
        run_cmd("copy_ovl", 1'b1, 0, 40, 80, 64'h0);
        chk("copy_ovl_c40", mem[40], 64'd80);
        chk("copy_ovl_c119", mem[119], 64'd159);

        // contention: CPU reads alongside a 1000-cell fill
        for (int i = 0; i < 32; i++) cpu_wr("pre_rnd", AW'(5000 + i), {$urandom, $urandom}, 8'hFF, 1);
        fork
            run_cmd("fill1000", 1'b0, 8000, 8000, 1000, 64'hA5A5_0000_1234_5678);
            begin
                tick();
                for (int k = 0; k < 40; k++) cpu_rd("contend", AW'($urandom_range(5000, 5031)), 3);
            end
        join

        // edges
        run_cmd("len0", 1'b0, 0, 300, 0, 64'hDEAD);
        run_cmd("wrap", 1'b0, 16380, 16380, 8, 64'h0F0F);
        chk("wrap_c16383", mem[16383], 64'h0F0F);
        chk("wrap_c3", mem[3], 64'h0F0F);
        chk("wrap_c4", mem[4], ref_mem[4]);
        run_cmd("full", 1'b0, 0, 0, N, 64'h0720_0720_0720_0720);

        // random mix
        for (int it = 0; it < 12; it++) begin
            int a, b, l;
            a = (it % 3 == 0) ? int'($urandom_range(N - 30, N - 1)) : int'($urandom_range(0, N - 1));
            b = (it % 2 == 0) ? (a + int'($urandom_range(0, 40))) % N : int'($urandom_range(0, N - 1));
            l = int'($urandom_range(0, 48));
            cpu_wr("rnd_cpu", AW'(a), {$urandom, $urandom}, 8'($urandom), 1);
            cpu_rd("rnd_cpu", AW'(a), 2);
            if ($urandom_range(0, 1) == 0) run_cmd("rnd_fill", 1'b0, a, b, l, {$urandom, $urandom});
            else run_cmd("rnd_copy", 1'b1, a, b, l, 64'h0);
        end

        // reset mid-copy after 10 cells
        run_cmd("pre_src", 1'b0, 200, 200, 80, 64'h1111);
        run_cmd("pre_dst", 1'b0, 300, 300, 80, 64'h2222);
        w0 = wr_cnt;
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_src = 14'd200; cmd_dst = 14'd300; cmd_len = 15'd80;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (wr_cnt - w0 < 10 && n < 400) begin tick(); n++; end
        chk("rst_mid reached10", 64'(wr_cnt - w0), 64'd10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid async_ctrl", 64'({cmd_ready, busy, done, cpu_ack, ram_cs, ram_we}), 64'b100000);
        chk("rst_mid async_adr", 64'(ram_adr), 64'd0);
        w0 = wr_cnt;
        repeat (4) tick();
        chk("rst_mid no_writes", 64'(wr_cnt - w0), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_mid ready_after", 64'({cmd_ready, busy}), 64'b10);
        for (int i = 79; i >= 70; i--) ref_mem[300 + i] = ref_mem[200 + i];
        cmp_mem("rst_mid partial");
        fa = 64'h3333_4444;
        run_cmd("post_rst", 1'b0, 0, 600, 16, fa);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
